ack_waiter: RTL

//  Sender-side partner to the ACK generator. Sits between the MAC transmit controller and the

---
 rtl/ack_waiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ack_waiter.sv
// Waits for the type-3 ACK matching the last tracked type-2 send; pulses ack_ok, retransmit or give_up.
// Latency: one cycle from the deciding event to the registered pulse. No backpressure; every strobe is consumed.
module ack_waiter #(
    parameter int          TIMEOUT_CYCLES = 50_000,
    parameter int          MAX_RETRIES    = 5,
    parameter logic [7:0]  ACK_TYPE       = 8'h33,
    parameter logic [7:0]  BCAST_ADDR     = 8'h2A,
    localparam int         RW             = $clog2(MAX_RETRIES + 1),
    localparam int         TW             = $clog2(TIMEOUT_CYCLES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    mac_addr,
    input  logic          tx_type2_sent,
    input  logic [7:0]    tx_dest,
    input  logic [7:0]    rx_byte,
    input  logic          rx_valid,
    input  logic          rx_eof,
    input  logic          rx_error,
    output logic          waiting,
    output logic          ack_ok,
    output logic          retransmit,
    output logic          give_up,
    output logic [RW-1:0] retry_count
);
    typedef enum logic [1:0] {IDLE, WAIT_ACK, RESEND} state_t;

    state_t        state_q;
    logic [TW-1:0] timer_q;
    logic [RW-1:0] retry_q;
    logic [7:0]    exp_src_q;
    logic [7:0]    hdr_dst_q;
    logic [7:0]    hdr_src_q;
    logic [7:0]    hdr_type_q;
    logic [1:0]    hdr_cnt_q;
    logic          ack_ok_q;
    logic          retransmit_q;
    logic          give_up_q;

    logic tracked_send;
    logic ack_hit;
    logic timeout;

    assign tracked_send = tx_type2_sent && (tx_dest != BCAST_ADDR);
    // Header fields are checked against the registered copies in the same cycle the parser clears them.
    assign ack_hit = rx_eof && (hdr_cnt_q == 2'd3) && (hdr_dst_q == mac_addr)
                     && (hdr_src_q == exp_src_q) && (hdr_type_q == ACK_TYPE);
    assign timeout = (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_cnt_q  <= 2'd0;
            hdr_dst_q  <= 8'd0;
            hdr_src_q  <= 8'd0;
            hdr_type_q <= 8'd0;
        end else if (rx_eof || rx_error) begin
            hdr_cnt_q <= 2'd0;
        end else if (rx_valid && (hdr_cnt_q != 2'd3)) begin
            case (hdr_cnt_q)
                2'd0:    hdr_dst_q  <= rx_byte;
                2'd1:    hdr_src_q  <= rx_byte;
                default: hdr_type_q <= rx_byte;
            endcase
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            retry_q      <= '0;
            exp_src_q    <= 8'd0;
            ack_ok_q     <= 1'b0;
            retransmit_q <= 1'b0;
            give_up_q    <= 1'b0;
        end else begin
            ack_ok_q     <= 1'b0;
            retransmit_q <= 1'b0;
            give_up_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tracked_send) begin
                        exp_src_q <= tx_dest;
                        timer_q   <= '0;
                        retry_q   <= '0;
                        state_q   <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (ack_hit) begin
                        ack_ok_q <= 1'b1;
                        timer_q  <= '0;
                        state_q  <= IDLE;
                    end else if (timeout) begin
                        timer_q <= '0;
                        if (retry_q < RW'(MAX_RETRIES)) begin
                            retransmit_q <= 1'b1;
                            retry_q      <= retry_q + 1'b1;
                            state_q      <= RESEND;
                        end else begin
                            give_up_q <= 1'b1;
                            state_q   <= IDLE;
                        end
                    end else if (tracked_send) begin
                        exp_src_q <= tx_dest;
                        timer_q   <= '0;
                        retry_q   <= '0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                RESEND: begin
                    timer_q <= '0;
                    if (tx_type2_sent) begin
                        state_q <= WAIT_ACK;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign waiting     = (state_q == WAIT_ACK) || (state_q == RESEND);
    assign ack_ok      = ack_ok_q;
    assign retransmit  = retransmit_q;
    assign give_up     = give_up_q;
    assign retry_count = retry_q;
endmodule
